mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum busy-state cycles before abort (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req input 1, if_addr input ADDR_W  instruction-fetch request and address.
REQ-006 SHALL have ports if_rdata output 32, if_valid output 1  fetch data and one-cycle completion pulse.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W, d_wdata input 32, d_be input 4  data-stage load/store request.
REQ-008 SHALL have ports d_rdata output 32, d_valid output 1  load data and one-cycle completion pulse (also pulses for stores).
REQ-009 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output 32, mem_be output 4  shared single-port memory request.
REQ-010 SHALL have ports mem_rdata input 32, mem_ready input 1  memory read data and completion.
REQ-011 SHALL have ports stall output 1, err output 1  pipeline stall and one-cycle timeout pulse.

Function
REQ-012 SHALL implement FSM states IDLE, IF_BUSY, D_BUSY.
REQ-013 SHALL, in IDLE with any request asserted, grant one requester and enter IF_BUSY or D_BUSY on the next edge.
REQ-014 SHALL latch address, we, wdata, be of the granted requester at grant; if-grants drive mem_we=0, mem_be=4'hF.
REQ-015 SHALL hold mem_req=1 and the latched fields stable throughout BUSY states; mem_req=0 in IDLE.
REQ-016 SHALL, in a BUSY state with mem_ready=1, register mem_rdata into the winner's rdata, pulse its valid for exactly one cycle, and return to IDLE.
REQ-017 SHALL give minimum request-to-valid latency of 2 cycles (grant edge, then mem_ready in first busy cycle).
REQ-018 SHALL hold if_rdata/d_rdata stable between completions.
REQ-019 SHALL complete a latched transaction even if its req deasserts mid-operation; valid still pulses.
REQ-020 SHALL drive stall=1 whenever (if_req or d_req) is high and the corresponding valid is not pulsing that cycle.
REQ-021 SHALL count busy cycles in an 8-bit counter cleared at grant; on reaching TIMEOUT without mem_ready, pulse err and winner's valid with rdata=0, return to IDLE.
REQ-022 SHALL ignore mem_ready in IDLE.
REQ-023 SHALL never have if_valid and d_valid high in the same cycle.

Reset
REQ-024 SHALL, while reset=0, force state IDLE, counter 0, all outputs 0 (rdata buses 0), asynchronously, aborting any in-flight transaction without valid.
REQ-025 SHALL leave reset synchronously with the first grant possible on the first edge after reset rises.

Configuration
REQ-026 SHALL support macro MEM_ARB_RR_EN: defined -> round-robin on simultaneous requests (last-granted flag, reset to "fetch", so first tie goes to data); undefined -> fixed priority, data always wins ties.

Verification
REQ-027 SHALL cover: if_req=1, if_addr=0x40, mem_ready high 1st busy cycle, mem_rdata=0x00500093 -> mem_addr=0x40, if_valid pulse, if_rdata=0x00500093 at cycle 2.
REQ-028 SHALL cover: if_req and d_req (store, addr 0x100, wdata 0xDEADBEEF, be 0xF) same cycle, macro undefined -> data served first with mem_we=1, then fetch; stall high until each valid.
REQ-029 SHALL cover: MEM_ARB_RR_EN defined, both requests held continuously for 4 grants -> order data, fetch, data, fetch.
REQ-030 SHALL cover: TIMEOUT=4, mem_ready held 0 -> err and d_valid pulse 4 busy cycles after grant, d_rdata=0, FSM back to IDLE.
REQ-031 SHALL cover: reset=0 asserted during D_BUSY -> mem_req, stall, d_valid drop immediately; no valid after reset release until new request.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around mem_arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic [31:0]       d_rdata;
    logic              d_valid;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        output if_rdata, if_valid, d_rdata, d_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        input  if_rdata, if_valid, d_rdata, d_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory, with busy timeout.
// Optional MEM_ARB_RR_EN: round-robin on ties; otherwise data always wins ties.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;

    logic              pick_d;
    logic              done;
    logic [31:0]       done_data;
    logic [7:0]        cnt_inc;

`ifdef MEM_ARB_RR_EN
    logic last_if_q, last_if_d;
    // On a tie, serve data only if fetch was the last one granted.
    assign pick_d = bus.d_req && (!bus.if_req || last_if_q);
`else
    assign pick_d = bus.d_req;
`endif

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        done       = 1'b0;
        done_data  = 32'h0;
`ifdef MEM_ARB_RR_EN
        last_if_d  = last_if_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.d_req) begin
                    cnt_d = 8'd0;
                    if (pick_d) begin
                        state_d = StDBusy;
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                        be_d    = bus.d_be;
                    end else begin
                        state_d = StIfBusy;
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = 32'h0;
                        be_d    = 4'hF;
                    end
`ifdef MEM_ARB_RR_EN
                    last_if_d = !pick_d;
`endif
                end
            end
            StIfBusy, StDBusy: begin
                if (bus.mem_ready) begin
                    done      = 1'b1;
                    done_data = bus.mem_rdata;
                end else if (cnt_inc == TimeoutCnt) begin
                    // Abort: complete toward the winner with zero data and flag the error.
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (done) begin
                    state_d = StIdle;
                    if (state_q == StDBusy) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = done_data;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = done_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        mem_req_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            mem_req_q  <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_if_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            mem_req_q  <= mem_req_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
`ifdef MEM_ARB_RR_EN
            last_if_q  <= last_if_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.err       = err_q;
    // Gated by reset so stall drops the moment reset is asserted.
    assign bus.stall     = reset & ((bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q));
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, random vs model.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.d_be      = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_be;
        logic        e_if_valid;
        logic        e_d_valid;
        logic        e_stall;
        logic        e_err;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[8];

    // Reference model state: the pending transaction and what is visible this cycle.
    bit          m_busy;
    bit          m_is_d;
    logic [31:0] m_addr;
    bit          m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    int          m_age;
    bit          m_if_valid, m_d_valid, m_err;
    logic [31:0] m_if_rdata, m_d_rdata;
    bit          m_last_if;

    task automatic model_reset();
        m_busy = 0; m_is_d = 0; m_addr = 0; m_we = 0; m_wdata = 0; m_be = 0; m_age = 0;
        m_if_valid = 0; m_d_valid = 0; m_err = 0; m_if_rdata = 0; m_d_rdata = 0;
        m_last_if = 1;
    endtask

    task automatic model_step();
        bit serve_d;
        m_if_valid = 0;
        m_d_valid  = 0;
        m_err      = 0;
        if (!m_busy) begin
            if (bus.if_req || bus.d_req) begin
`ifdef MEM_ARB_RR_EN
                if (bus.if_req && bus.d_req) serve_d = m_last_if;
                else serve_d = bus.d_req;
`else
                serve_d = bus.d_req;
`endif
                m_busy = 1; m_is_d = serve_d; m_age = 0; m_last_if = !serve_d;
                if (serve_d) begin
                    m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata; m_be = bus.d_be;
                end else begin
                    m_addr = bus.if_addr; m_we = 0; m_wdata = 0; m_be = 4'hF;
                end
            end
        end else begin
            m_age++;
            if (bus.mem_ready || m_age == TO) begin
                logic [31:0] data;
                data = bus.mem_ready ? bus.mem_rdata : 32'h0;
                m_err = !bus.mem_ready;
                m_busy = 0;
                if (m_is_d) begin m_d_valid = 1; m_d_rdata = data; end
                else begin m_if_valid = 1; m_if_rdata = data; end
            end
        end
    endtask

    task automatic model_check();
        bit exp_stall;
        exp_stall = (bus.if_req && !m_if_valid) || (bus.d_req && !m_d_valid);
        chk("rnd_mem_req", 32'(bus.mem_req), 32'(m_busy));
        chk("rnd_stall", 32'(bus.stall), 32'(exp_stall));
        chk("rnd_if_valid", 32'(bus.if_valid), 32'(m_if_valid));
        chk("rnd_d_valid", 32'(bus.d_valid), 32'(m_d_valid));
        chk("rnd_err", 32'(bus.err), 32'(m_err));
        chk("rnd_if_rdata", bus.if_rdata, m_if_rdata);
        chk("rnd_d_rdata", bus.d_rdata, m_d_rdata);
        chk("rnd_valid_excl", 32'(bus.if_valid & bus.d_valid), 32'h0);
        if (m_busy) begin
            chk("rnd_mem_addr", bus.mem_addr, m_addr);
            chk("rnd_mem_we", 32'(bus.mem_we), 32'(m_we));
            chk("rnd_mem_be", 32'(bus.mem_be), 32'(m_be));
            if (m_we) chk("rnd_mem_wdata", bus.mem_wdata, m_wdata);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [1:0] order[4];
        int         n_done;

        vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00500093,
                    1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0};
        vecs[3] = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00500093, 32'h0};
        vecs[4] = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 32'h1234,
                    1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0,
                    32'h00500093, 32'h0};
        vecs[5] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00500093, 32'h1234};
        vecs[6] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00A00113,
                    1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00500093,
                    32'h1234};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A00113, 32'h1234};

        clear_inputs();
        @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_valids", {30'h0, bus.if_valid, bus.d_valid}, 32'h0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
        do_reset();

        // Directed table: fetch with minimum latency, then store/fetch tie.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            bus.if_req = v.if_req;   bus.if_addr = v.if_addr;
            bus.d_req = v.d_req;     bus.d_we = v.d_we;       bus.d_addr = v.d_addr;
            bus.d_wdata = v.d_wdata; bus.d_be = v.d_be;
            bus.mem_ready = v.mem_ready; bus.mem_rdata = v.mem_rdata;
            #1;
            chk($sformatf("vec%0d_mem_req", i), 32'(bus.mem_req), 32'(v.e_mem_req));
            chk($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(v.e_if_valid));
            chk($sformatf("vec%0d_d_valid", i), 32'(bus.d_valid), 32'(v.e_d_valid));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(v.e_stall));
            chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(v.e_err));
            chk($sformatf("vec%0d_if_rdata", i), bus.if_rdata, v.e_if_rdata);
            chk($sformatf("vec%0d_d_rdata", i), bus.d_rdata, v.e_d_rdata);
            if (v.e_mem_req) begin
                chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, v.e_mem_addr);
                chk($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(v.e_mem_we));
                chk($sformatf("vec%0d_mem_be", i), 32'(bus.mem_be), 32'(v.e_mem_be));
                if (v.e_mem_we) chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, v.e_mem_wdata);
            end
            @(negedge clk);
        end

        // Timeout: load with memory never ready; requester drops req after grant.
        clear_inputs();
        bus.d_req = 1'b1; bus.d_addr = 32'h200;
        #1 chk("to_req_stall", 32'(bus.stall), 32'h1);
        @(negedge clk);
        bus.d_req = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            #1;
            chk($sformatf("to_busy%0d_mem_req", k), 32'(bus.mem_req), 32'h1);
            chk($sformatf("to_busy%0d_flags", k), {30'h0, bus.err, bus.d_valid}, 32'h0);
            chk($sformatf("to_busy%0d_addr", k), bus.mem_addr, 32'h200);
            @(negedge clk);
        end
        #1;
        chk("to_err", 32'(bus.err), 32'h1);
        chk("to_d_valid", 32'(bus.d_valid), 32'h1);
        chk("to_d_rdata", bus.d_rdata, 32'h0);
        chk("to_idle", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        #1 chk("to_err_pulse", {30'h0, bus.err, bus.d_valid}, 32'h0);

        // mem_ready while idle must be ignored.
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            #1 chk("idle_ready_ignored", {29'h0, bus.mem_req, bus.if_valid, bus.d_valid}, 32'h0);
        end
        chk("idle_rdata_held", bus.d_rdata, 32'h0);

        // Reset asserted mid-transaction.
        @(negedge clk);
        clear_inputs();
        bus.d_req = 1'b1; bus.d_addr = 32'h300;
        @(negedge clk);
        #1 chk("rb_busy", 32'(bus.mem_req), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rb_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rb_stall", 32'(bus.stall), 32'h0);
        chk("rb_d_valid", 32'(bus.d_valid), 32'h0);
        chk("rb_if_rdata", bus.if_rdata, 32'h0);
        chk("rb_mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        bus.d_req = 1'b0; bus.mem_ready = 1'b1; reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("rb_no_valid", {29'h0, bus.mem_req, bus.if_valid, bus.d_valid}, 32'h0);
        end

        // First grant on the first edge after reset release.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; bus.mem_ready = 1'b0; bus.d_req = 1'b1; bus.d_addr = 32'h44;
        @(negedge clk);
        #1 chk("rel_first_grant", 32'(bus.mem_req), 32'h1);
        bus.d_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A;
        @(negedge clk);
        #1 chk("rel_done", bus.d_rdata, 32'h5A5A);

        // Both requesters held: grant order under tie.
        do_reset();
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.mem_ready = 1'b1;
        n_done = 0;
        for (int c = 0; c < 16 && n_done < 4; c++) begin
            @(negedge clk);
            #1;
            if (bus.if_valid) begin order[n_done] = 2'd1; n_done++; end
            else if (bus.d_valid) begin order[n_done] = 2'd2; n_done++; end
        end
        chk("tie_grant_count", 32'(n_done), 32'd4);
        for (int k = 0; k < n_done; k++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("tie_order%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'd2 : 32'd1);
`else
            chk($sformatf("tie_order%0d", k), 32'(order[k]), 32'd2);
`endif
        end

        // Random traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.if_req    = ($urandom_range(0, 3) != 0);
            bus.if_addr   = $urandom();
            bus.d_req     = ($urandom_range(0, 2) != 0);
            bus.d_we      = $urandom_range(0, 1) == 1;
            bus.d_addr    = $urandom();
            bus.d_wdata   = $urandom();
            bus.d_be      = 4'($urandom());
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom();
            #1;
            model_check();
            model_step();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
